prefix_adder_seq: RTL and testbench

//   Iterative parallel-prefix (Kogge-Stone) adder. Evaluates one prefix level per clock,

---
 rtl/prefix_adder_seq.sv | 127 ++++++++++++
 tb/tb_prefix_adder_seq.sv | 361 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/prefix_adder_seq.sv
// prefix_adder_seq: iterative Kogge-Stone adder.
// A generate/propagate bank is folded one prefix level per clock, so an add
// takes LEVELS+1 edges after acceptance. The carry-in is merged into bit 0
// up front, which makes every final G[i] the carry out of bit i directly.
module prefix_adder_seq #(
   parameter int WIDTH = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             cin,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] sum,
   output logic             cout
);

   localparam int LEVELS = $clog2(WIDTH);
   localparam int LVL_W  = (LEVELS > 1) ? $clog2(LEVELS) : 1;
   localparam logic [LVL_W-1:0] LAST_LVL = LVL_W'(LEVELS - 1);

   typedef enum logic [1:0] {
      S_IDLE   = 2'd0,
      S_PREFIX = 2'd1,
      S_SUM    = 2'd2
   } state_t;

   state_t           state_q, state_d;
   logic [WIDTH-1:0] g_q, g_d;
   logic [WIDTH-1:0] p_q, p_d;
   logic [WIDTH-1:0] pr_q, pr_d;
   logic [WIDTH-1:0] sum_q, sum_d;
   logic             cinr_q, cinr_d;
   logic             cout_q, cout_d;
   logic             done_q, done_d;
   logic [LVL_W-1:0] lvl_q, lvl_d;

   // State register; reset aborts any add in flight.
   always_ff @(posedge clk) begin
      if (rst) state_q <= S_IDLE;
      else     state_q <= state_d;
   end

   // Next-state: accept in IDLE, walk the prefix levels, then form the sum.
   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE:   if (start) state_d = S_PREFIX;
         S_PREFIX: if (lvl_q == LAST_LVL) state_d = S_SUM;
         S_SUM:    state_d = S_IDLE;
         default:  state_d = S_IDLE;
      endcase
   end

   // Outputs: busy follows the FSM, result fields come from their registers.
   always_comb begin
      busy = (state_q != S_IDLE);
      done = done_q;
      sum  = sum_q;
      cout = cout_q;
   end

   // Datapath next values; the prefix step shifts by d = 2^level, and P is
   // shifted with ones filled in so bits below d keep their P unchanged.
   always_comb begin
      int d;
      g_d    = g_q;
      p_d    = p_q;
      pr_d   = pr_q;
      cinr_d = cinr_q;
      lvl_d  = lvl_q;
      sum_d  = sum_q;
      cout_d = cout_q;
      done_d = 1'b0;
      d      = 1 << lvl_q;
      case (state_q)
         S_IDLE: begin
            if (start) begin
               pr_d   = a ^ b;
               g_d    = a & b;
               p_d    = a ^ b;
               g_d[0] = (a[0] & b[0]) | ((a[0] ^ b[0]) & cin);
               p_d[0] = 1'b0;
               cinr_d = cin;
               lvl_d  = '0;
            end
         end
         S_PREFIX: begin
            g_d   = g_q | (p_q & (g_q << d));
            p_d   = p_q & ~((~p_q) << d);
            lvl_d = (lvl_q == LAST_LVL) ? '0 : lvl_q + LVL_W'(1);
         end
         S_SUM: begin
            sum_d  = pr_q ^ {g_q[WIDTH-2:0], cinr_q};
            cout_d = g_q[WIDTH-1];
            done_d = 1'b1;
         end
         default: ;
      endcase
   end

   // Datapath registers; done is a single-cycle pulse, sum/cout hold.
   always_ff @(posedge clk) begin
      if (rst) begin
         g_q    <= '0;
         p_q    <= '0;
         pr_q   <= '0;
         sum_q  <= '0;
         cinr_q <= 1'b0;
         cout_q <= 1'b0;
         done_q <= 1'b0;
         lvl_q  <= '0;
      end else begin
         g_q    <= g_d;
         p_q    <= p_d;
         pr_q   <= pr_d;
         sum_q  <= sum_d;
         cinr_q <= cinr_d;
         cout_q <= cout_d;
         done_q <= done_d;
         lvl_q  <= lvl_d;
      end
   end

endmodule

// File: tb/tb_prefix_adder_seq.sv
// Bench for prefix_adder_seq: a 16-bit and an 8-bit instance, expected sums
// queued when an add is issued and compared when done pulses.
module tb_prefix_adder_seq;

   logic        clk = 1'b0;
   logic        rst;
   logic        start16, cin16, busy16, done16, cout16;
   logic [15:0] a16, b16, sum16;
   logic        start8, cin8, busy8, done8, cout8;
   logic [7:0]  a8, b8, sum8;

   int checks = 0;
   int errors = 0;

   logic [16:0] q16[$];
   logic [8:0]  q8[$];
   logic [16:0] exp16_m;
   logic [8:0]  exp8_m;

   always #5 clk = ~clk;

   prefix_adder_seq #(.WIDTH(16)) dut16 (
      .clk(clk), .rst(rst), .start(start16), .a(a16), .b(b16), .cin(cin16),
      .busy(busy16), .done(done16), .sum(sum16), .cout(cout16));

   prefix_adder_seq #(.WIDTH(8)) dut8 (
      .clk(clk), .rst(rst), .start(start8), .a(a8), .b(b8), .cin(cin8),
      .busy(busy8), .done(done8), .sum(sum8), .cout(cout8));

   // Scoreboard for the 16-bit instance.
   always @(negedge clk) begin
      if (done16) begin
         checks++;
         if (q16.size() == 0) begin
            errors++;
            $display("FAIL sb16_unexpected_done: got cout=%0b sum=%h, required no done", cout16, sum16);
         end else begin
            exp16_m = q16.pop_front();
            if ({cout16, sum16} !== exp16_m) begin
               errors++;
               $display("FAIL sb16_result: got cout=%0b sum=%h, required cout=%0b sum=%h",
                        cout16, sum16, exp16_m[16], exp16_m[15:0]);
            end
         end
      end
   end

   // Scoreboard for the 8-bit instance.
   always @(negedge clk) begin
      if (done8) begin
         checks++;
         if (q8.size() == 0) begin
            errors++;
            $display("FAIL sb8_unexpected_done: got cout=%0b sum=%h, required no done", cout8, sum8);
         end else begin
            exp8_m = q8.pop_front();
            if ({cout8, sum8} !== exp8_m) begin
               errors++;
               $display("FAIL sb8_result: got cout=%0b sum=%h, required cout=%0b sum=%h",
                        cout8, sum8, exp8_m[8], exp8_m[7:0]);
            end
         end
      end
   end

   task automatic drive16(input logic [15:0] av, input logic [15:0] bv, input logic cv);
      a16 = av; b16 = bv; cin16 = cv; start16 = 1'b1;
      q16.push_back({1'b0, av} + {1'b0, bv} + {16'd0, cv});
   endtask

   task automatic drive8(input logic [7:0] av, input logic [7:0] bv, input logic cv);
      a8 = av; b8 = bv; cin8 = cv; start8 = 1'b1;
      q8.push_back({1'b0, av} + {1'b0, bv} + {8'd0, cv});
   endtask

   task automatic test_reset;
      rst = 1'b1;
      repeat (3) @(negedge clk);
      checks++;
      if ({busy16, done16, cout16, sum16} !== 19'd0) begin
         errors++;
         $display("FAIL reset16: got busy=%0b done=%0b cout=%0b sum=%h, required all 0",
                  busy16, done16, cout16, sum16);
      end
      checks++;
      if ({busy8, done8, cout8, sum8} !== 11'd0) begin
         errors++;
         $display("FAIL reset8: got busy=%0b done=%0b cout=%0b sum=%h, required all 0",
                  busy8, done8, cout8, sum8);
      end
      rst = 1'b0;
   endtask

   task automatic test_idle;
      int busy_seen;
      busy_seen = 0;
      for (int k = 0; k < 4; k++) begin
         @(negedge clk);
         if (busy16 || done16) busy_seen++;
      end
      checks++;
      if (busy_seen != 0) begin
         errors++;
         $display("FAIL idle_no_start: got %0d busy/done cycles, required 0", busy_seen);
      end
   endtask

   task automatic test_wrap;
      int busy_cnt, dones;
      busy_cnt = 0; dones = 0;
      @(negedge clk);
      drive16(16'hFFFF, 16'h0001, 1'b0);
      for (int k = 1; k <= 12; k++) begin
         @(negedge clk);
         if (k == 1) start16 = 1'b0;
         if (busy16) busy_cnt++;
         if (done16) dones++;
      end
      checks++;
      if (busy_cnt != 5) begin
         errors++;
         $display("FAIL wrap_busy_cycles: got %0d, required 5", busy_cnt);
      end
      checks++;
      if (dones != 1) begin
         errors++;
         $display("FAIL wrap_done_pulses: got %0d, required 1", dones);
      end
   endtask

   task automatic test_latency;
      int seen;
      logic [16:0] res;
      seen = 0; res = '0;
      @(negedge clk);
      drive16(16'h1234, 16'h4321, 1'b1);
      for (int k = 1; k <= 12; k++) begin
         @(negedge clk);
         if (k == 1) start16 = 1'b0;
         if (done16 && seen == 0) begin
            seen = k;
            res = {cout16, sum16};
         end
      end
      checks++;
      if (seen != 6) begin
         errors++;
         $display("FAIL latency16: got done %0d edges after accept, required 5", seen - 1);
      end
      checks++;
      if (res !== 17'h05556) begin
         errors++;
         $display("FAIL latency16_value: got %h, required 05556", res);
      end
   endtask

   task automatic test_ignore_busy;
      int seen, dones;
      logic busy3;
      logic [16:0] res;
      seen = 0; dones = 0; busy3 = 1'b0; res = '0;
      @(negedge clk);
      drive16(16'hFFFF, 16'h0001, 1'b0);
      for (int k = 1; k <= 12; k++) begin
         @(negedge clk);
         if (k == 1) start16 = 1'b0;
         if (k == 2) begin
            a16 = 16'h0000; b16 = 16'h0000; cin16 = 1'b0; start16 = 1'b1;
         end
         if (k == 3) begin
            start16 = 1'b0;
            busy3 = busy16;
         end
         if (done16) begin
            dones++;
            if (seen == 0) begin
               seen = k;
               res = {cout16, sum16};
            end
         end
      end
      checks++;
      if (busy3 !== 1'b1) begin
         errors++;
         $display("FAIL ignore_busy_held: got busy=%0b, required 1", busy3);
      end
      checks++;
      if (dones != 1 || seen != 6) begin
         errors++;
         $display("FAIL ignore_done: got %0d pulses first at %0d, required 1 at 6", dones, seen);
      end
      checks++;
      if (res !== 17'h10000) begin
         errors++;
         $display("FAIL ignore_value: got %h, required 10000", res);
      end
      checks++;
      if (q16.size() != 0) begin
         errors++;
         $display("FAIL ignore_queue: got %0d pending, required 0", q16.size());
      end
   endtask

   task automatic test_hold;
      logic [17:0] late;
      late = '0;
      @(negedge clk);
      drive16(16'h8000, 16'h8000, 1'b1);
      for (int k = 1; k <= 9; k++) begin
         @(negedge clk);
         if (k == 1) start16 = 1'b0;
         if (k == 9) late = {done16, cout16, sum16};
      end
      checks++;
      if (late !== 18'h10001) begin
         errors++;
         $display("FAIL hold_after_done: got done=%0b cout=%0b sum=%h, required done=0 cout=1 sum=0001",
                  late[17], late[16], late[15:0]);
      end
      checks++;
      if (busy16 !== 1'b0) begin
         errors++;
         $display("FAIL hold_busy: got %0b, required 0", busy16);
      end
   endtask

   task automatic test_rst_mid;
      int dones, seen;
      logic [18:0] after_rst;
      dones = 0; seen = 0; after_rst = '1;
      @(negedge clk);
      drive16(16'h1111, 16'h2222, 1'b0);
      for (int k = 1; k <= 14; k++) begin
         @(negedge clk);
         if (k == 1) start16 = 1'b0;
         if (k == 3) rst = 1'b1;
         if (k == 4) begin
            after_rst = {busy16, done16, cout16, sum16};
            rst = 1'b0;
            q16.delete();
         end
         if (done16) dones++;
      end
      checks++;
      if (after_rst !== 19'd0) begin
         errors++;
         $display("FAIL rst_mid_outputs: got busy=%0b done=%0b cout=%0b sum=%h, required all 0",
                  after_rst[18], after_rst[17], after_rst[16], after_rst[15:0]);
      end
      checks++;
      if (dones != 0) begin
         errors++;
         $display("FAIL rst_mid_no_done: got %0d pulses, required 0", dones);
      end
      @(negedge clk);
      drive16(16'h0F0F, 16'h00F1, 1'b0);
      for (int k = 1; k <= 12; k++) begin
         @(negedge clk);
         if (k == 1) start16 = 1'b0;
         if (done16 && seen == 0) seen = k;
      end
      checks++;
      if (seen != 6) begin
         errors++;
         $display("FAIL rst_mid_next_add: got done at %0d, required 6", seen);
      end
   endtask

   task automatic test_w8;
      int seen1, seen2;
      logic busy_after;
      seen1 = 0; seen2 = 0; busy_after = 1'b0;
      @(negedge clk);
      drive8(8'hFF, 8'hFF, 1'b1);
      for (int k = 1; k <= 20; k++) begin
         @(negedge clk);
         if (k == 1) start8 = 1'b0;
         if (seen1 != 0 && k == seen1 + 1) begin
            start8 = 1'b0;
            busy_after = busy8;
         end
         if (done8) begin
            if (seen1 == 0) begin
               seen1 = k;
               drive8(8'h5A, 8'h3C, 1'b0);
            end else if (seen2 == 0) begin
               seen2 = k;
            end
         end
      end
      checks++;
      if (seen1 != 5) begin
         errors++;
         $display("FAIL w8_latency: got done at %0d, required 5", seen1);
      end
      checks++;
      if (busy_after !== 1'b1) begin
         errors++;
         $display("FAIL w8_accept_in_done: got busy=%0b, required 1", busy_after);
      end
      checks++;
      if (seen2 - seen1 != 5) begin
         errors++;
         $display("FAIL w8_second_latency: got %0d, required 5", seen2 - seen1);
      end
   endtask

   task automatic test_back_to_back;
      int issued, dones, last, lat_bad;
      issued = 1; dones = 0; last = 0; lat_bad = 0;
      @(negedge clk);
      drive16(16'($urandom), 16'($urandom), 1'($urandom));
      for (int k = 1; k <= 80 && dones < 6; k++) begin
         @(negedge clk);
         start16 = 1'b0;
         if (done16) begin
            dones++;
            if (k - last != 6) lat_bad++;
            if (issued < 6) begin
               drive16(16'($urandom), 16'($urandom), 1'($urandom));
               issued++;
               last = k;
            end
         end
      end
      checks++;
      if (dones != 6) begin
         errors++;
         $display("FAIL b2b_count: got %0d results, required 6", dones);
      end
      checks++;
      if (lat_bad != 0) begin
         errors++;
         $display("FAIL b2b_latency: got %0d late results, required 0", lat_bad);
      end
   endtask

   initial begin
      rst = 1'b1;
      start16 = 1'b0; a16 = '0; b16 = '0; cin16 = 1'b0;
      start8  = 1'b0; a8  = '0; b8  = '0; cin8  = 1'b0;
      test_reset();
      test_idle();
      test_wrap();
      test_latency();
      test_ignore_busy();
      test_hold();
      test_rst_mid();
      test_w8();
      test_back_to_back();
      repeat (3) @(negedge clk);
      checks++;
      if (q16.size() != 0 || q8.size() != 0) begin
         errors++;
         $display("FAIL queues_drained: got %0d/%0d pending, required 0/0", q16.size(), q8.size());
      end
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
